// File: rtl/router_fifo_pkt.sv
// Packet-aware synchronous FIFO for one router output channel.
// Buffers {lfd, byte} entries and tracks header/payload/parity framing on the read side.
module router_fifo_pkt #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     soft_rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic                     lfd_state,
    input  logic [DATA_W-1:0]        din,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic                     pkt_sop,
    output logic                     pkt_eop,
    output logic                     pkt_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = DATA_W - 1;
    localparam int LW = DATA_W - 2;

    logic [DATA_W:0]     mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [RW-1:0]       rem_q, rem_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                err_q, err_d;

    logic                wr_acc, rd_acc;
    logic [DATA_W:0]     rd_entry;
    logic                rd_lfd;
    logic [LW-1:0]       rd_len;

    // Handshake: wr_en/rd_en are requests; a write is taken when !full and a read
    // when !empty, both judged on pre-edge state. Rejected requests have no effect.
    assign wr_acc   = wr_en && (count_q != CW'(DEPTH));
    assign rd_acc   = rd_en && (count_q != '0);
    assign rd_entry = mem_q[rd_ptr_q];
    assign rd_lfd   = rd_entry[DATA_W];
    assign rd_len   = rd_entry[DATA_W-1:2];

    always_ff @(posedge clk) begin
        if (wr_acc && !soft_rst) begin
            mem_q[wr_ptr_q] <= {lfd_state, din};
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rem_d        = rem_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        err_d        = err_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            dout_d       = rd_entry[DATA_W-1:0];
            dout_valid_d = 1'b1;
            if (rd_lfd) begin
                // Header reloads len+1 so the final (parity) byte sees rem == 1.
                rem_d = RW'(rd_len) + RW'(1);
                sop_d = 1'b1;
                if (rem_q != '0) begin
                    err_d = 1'b1;
                end
            end else if (rem_q != '0) begin
                rem_d = rem_q - RW'(1);
                eop_d = (rem_q == RW'(1));
            end else begin
                err_d = 1'b1;
            end
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end

        if (soft_rst) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            rem_d        = '0;
            dout_d       = '0;
            dout_valid_d = 1'b0;
            sop_d        = 1'b0;
            eop_d        = 1'b0;
            err_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rem_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rem_q        <= rem_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            err_q        <= err_d;
        end
    end

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(AF_THRESH));
    assign count       = count_q;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign pkt_sop     = sop_q;
    assign pkt_eop     = eop_q;
    assign pkt_err     = err_q;

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Directed bench for router_fifo_pkt: default 8x16 instance plus a 12-bit x 64 instance
// for the maximum-length packet.
module tb_router_fifo_pkt;

    logic clk;
    logic rst;

    logic        a_soft, a_wr, a_rd, a_lfd;
    logic [7:0]  a_din;
    logic        a_full, a_empty, a_af;
    logic [4:0]  a_count;
    logic [7:0]  a_dout;
    logic        a_dv, a_sop, a_eop, a_err;

    logic        b_soft, b_wr, b_rd, b_lfd;
    logic [11:0] b_din;
    logic        b_full, b_empty, b_af;
    logic [6:0]  b_count;
    logic [11:0] b_dout;
    logic        b_dv, b_sop, b_eop, b_err;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    router_fifo_pkt dut_a (
        .clk(clk), .rst(rst), .soft_rst(a_soft), .wr_en(a_wr), .rd_en(a_rd),
        .lfd_state(a_lfd), .din(a_din), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .count(a_count), .dout(a_dout), .dout_valid(a_dv),
        .pkt_sop(a_sop), .pkt_eop(a_eop), .pkt_err(a_err)
    );

    router_fifo_pkt #(.DATA_W(12), .DEPTH(64), .AF_THRESH(60)) dut_b (
        .clk(clk), .rst(rst), .soft_rst(b_soft), .wr_en(b_wr), .rd_en(b_rd),
        .lfd_state(b_lfd), .din(b_din), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .count(b_count), .dout(b_dout), .dout_valid(b_dv),
        .pkt_sop(b_sop), .pkt_eop(b_eop), .pkt_err(b_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
        end
    endtask

    // Driver tasks for instance A
    task automatic a_write(input logic lfd, input logic [7:0] d);
        a_wr  = 1'b1;
        a_lfd = lfd;
        a_din = d;
        tick();
        a_wr  = 1'b0;
        a_lfd = 1'b0;
    endtask

    task automatic a_read();
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
    endtask

    task automatic a_flush();
        a_soft = 1'b1;
        tick();
        a_soft = 1'b0;
    endtask

    function automatic logic [11:0] b_data(input int idx);
        if (idx == 0)
            return 12'hFFF;
        else if (idx == 1024)
            return 12'h5A5;
        else
            return 12'((idx * 7 + 3) & 'hFFF);
    endfunction

    initial begin
        logic [7:0] exp_b;
        int widx, ridx, bm, cyc, bad, eops, eop_idx, maxc;
        logic wacc, racc;
        logic [31:0] rem_hdr;

        checks = 0;
        failures = 0;
        rst = 1'b0;
        a_soft = 0; a_wr = 0; a_rd = 0; a_lfd = 0; a_din = '0;
        b_soft = 0; b_wr = 0; b_rd = 0; b_lfd = 0; b_din = '0;
        tick();
        tick();

        // Reset state
        check("rst_full", a_full, 0);
        check("rst_empty", a_empty, 1);
        check("rst_af", a_af, 0);
        check("rst_count", a_count, 0);
        check("rst_dout", a_dout, 0);
        check("rst_dv", a_dv, 0);
        check("rst_sop", a_sop, 0);
        check("rst_eop", a_eop, 0);
        check("rst_err", a_err, 0);
        check("rst_b_empty", b_empty, 1);
        rst = 1'b1;
        tick();

        // Basic packet: header 0x0D (len 3, addr 1), 3 payload, parity
        a_write(1, 8'h0D);
        a_write(0, 8'h11);
        a_write(0, 8'h22);
        a_write(0, 8'h33);
        a_write(0, 8'h44);
        check("pkt1_count", a_count, 5);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        a_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                tick();
                a_rd = 1'b0;
            end else begin
                tick();
            end
            exp_b = exp_q.pop_front();
            check("pkt1_dv", a_dv, 1);
            check("pkt1_dout", a_dout, exp_b);
            check("pkt1_sop", a_sop, (i == 0));
            check("pkt1_eop", a_eop, (i == 4));
        end
        tick();
        check("pkt1_dv_off", a_dv, 0);
        check("pkt1_dout_hold", a_dout, 8'h44);
        check("pkt1_err", a_err, 0);
        check("pkt1_empty", a_empty, 1);

        // Fill 16 entries (one 16-byte packet), crossing pointer wrap
        for (int k = 1; k <= 16; k++) begin
            exp_b = (k == 1) ? 8'h38 : (k == 16) ? 8'hA5 : 8'(8'h40 + k);
            exp_q.push_back(exp_b);
            a_write(k == 1, exp_b);
            check("fill_count", a_count, k);
            check("fill_af", a_af, (k >= 14));
            check("fill_full", a_full, (k == 16));
        end
        a_write(1, 8'hEE);
        check("drop_count", a_count, 16);
        check("drop_full", a_full, 1);
        a_wr = 1'b1; a_din = 8'hEF; a_rd = 1'b1;
        tick();
        a_wr = 1'b0;
        check("fullrw_count", a_count, 15);
        check("fullrw_dout", a_dout, exp_q.pop_front());
        check("fullrw_sop", a_sop, 1);
        for (int i = 0; i < 15; i++) begin
            if (i == 14) begin
                tick();
                a_rd = 1'b0;
            end else begin
                tick();
            end
            check("rdback_dv", a_dv, 1);
            check("rdback_dout", a_dout, exp_q.pop_front());
            check("rdback_eop", a_eop, (i == 14));
        end
        tick();
        check("rdback_empty", a_empty, 1);
        check("rdback_err", a_err, 0);

        // Empty with simultaneous rd/wr: write taken, read rejected
        a_wr = 1'b1; a_rd = 1'b1; a_lfd = 1'b1; a_din = 8'h05;
        tick();
        a_wr = 1'b0; a_lfd = 1'b0;
        check("emptyrw_dv", a_dv, 0);
        check("emptyrw_count", a_count, 1);
        tick();
        a_rd = 1'b0;
        check("emptyrw_dout", a_dout, 8'h05);
        check("emptyrw_dv2", a_dv, 1);
        check("emptyrw_sop", a_sop, 1);
        check("emptyrw_rem", dut_a.rem_q, 2);
        check("emptyrw_err", a_err, 0);

        // Header while rem=2: error, rem reloads to len+1 = 3
        a_write(1, 8'h08);
        a_read();
        check("trunc_sop", a_sop, 1);
        check("trunc_err", a_err, 1);
        check("trunc_rem", dut_a.rem_q, 3);
        a_flush();
        check("flush_err", a_err, 0);
        check("flush_rem", dut_a.rem_q, 0);

        // Orphan byte with rem=0
        a_write(0, 8'h5A);
        a_read();
        check("orphan_dout", a_dout, 8'h5A);
        check("orphan_dv", a_dv, 1);
        check("orphan_err", a_err, 1);
        check("orphan_rem", dut_a.rem_q, 0);
        a_flush();

        // Zero-length header then parity
        a_write(1, 8'h02);
        a_write(0, 8'h77);
        a_read();
        check("len0_sop", a_sop, 1);
        check("len0_eop_hdr", a_eop, 0);
        a_read();
        check("len0_dout", a_dout, 8'h77);
        check("len0_eop", a_eop, 1);
        check("len0_sop_par", a_sop, 0);
        check("len0_err", a_err, 0);

        // soft_rst mid-packet with count=7, together with rd and wr
        a_write(1, 8'h18);
        for (int i = 1; i <= 7; i++) a_write(0, 8'(8'h60 + i));
        a_read();
        check("mid_count", a_count, 7);
        check("mid_rem", dut_a.rem_q, 7);
        a_soft = 1'b1; a_rd = 1'b1; a_wr = 1'b1; a_din = 8'h99;
        tick();
        a_soft = 1'b0; a_rd = 1'b0; a_wr = 1'b0;
        check("srst_count", a_count, 0);
        check("srst_empty", a_empty, 1);
        check("srst_dout", a_dout, 0);
        check("srst_dv", a_dv, 0);
        check("srst_err", a_err, 0);
        check("srst_rem", dut_a.rem_q, 0);

        // Asynchronous reset mid-packet, then a non-header read errors
        a_write(1, 8'h0C);
        a_write(0, 8'h21);
        a_read();
        #2 rst = 1'b0;
        #1;
        check("arst_count", a_count, 0);
        check("arst_dout", a_dout, 0);
        check("arst_dv", a_dv, 0);
        check("arst_rem", dut_a.rem_q, 0);
        rst = 1'b1;
        tick();
        a_write(0, 8'h33);
        a_read();
        check("arst_orphan_dout", a_dout, 8'h33);
        check("arst_orphan_err", a_err, 1);

        // Instance B: 1023-payload packet with backpressure
        widx = 0; bm = 0; ridx = 0; cyc = 0; bad = 0; eops = 0; eop_idx = -1;
        rem_hdr = '0;
        while (bm < 64 && cyc < 200) begin
            b_wr = 1'b1; b_lfd = (widx == 0); b_din = b_data(widx);
            tick();
            cyc++;
            widx++; bm++;
            if (b_count !== 7'(bm)) bad++;
        end
        b_wr = 1'b0;
        maxc = b_count;
        check("b_fill_count", b_count, 64);
        check("b_fill_full", b_full, 1);
        check("b_fill_af", b_af, 1);
        b_wr = 1'b1; b_lfd = 1'b0; b_din = b_data(widx);
        tick();
        check("b_drop_count", b_count, 64);
        cyc = 0;
        while (ridx < 1025 && cyc < 4000) begin
            wacc = (widx < 1025) && (bm < 64);
            racc = (bm > 0);
            b_wr  = (widx < 1025);
            b_lfd = 1'b0;
            b_din = b_data((widx < 1025) ? widx : 0);
            b_rd  = 1'b1;
            tick();
            cyc++;
            if (wacc) widx++;
            bm = bm + int'(wacc) - int'(racc);
            if (int'(b_count) > maxc) maxc = int'(b_count);
            if (b_count !== 7'(bm)) bad++;
            if (racc) begin
                if (b_dout !== b_data(ridx) || b_dv !== 1'b1 || b_sop !== (ridx == 0)) bad++;
                if (b_eop) begin
                    eops++;
                    eop_idx = ridx;
                end
                if (ridx == 0) rem_hdr = 32'(dut_b.rem_q);
                ridx++;
            end else if (b_dv !== 1'b0) begin
                bad++;
            end
        end
        b_rd = 1'b0; b_wr = 1'b0;
        check("b_reads_done", ridx, 1025);
        check("b_data_errs", bad, 0);
        check("b_rem_hdr", rem_hdr, 1024);
        check("b_eop_count", eops, 1);
        check("b_eop_idx", eop_idx, 1024);
        check("b_count_max", maxc, 64);
        check("b_err", b_err, 0);
        check("b_empty", b_empty, 1);
        check("b_rem_end", dut_b.rem_q, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
